// File: rtl/bidir_shift_tx.sv
// Parallel-in, serial-out transmitter feeding a bidirectional shift register.
// The transmitter accepts one WIDTH-bit word over a valid/ready handshake.
// It then streams the word one bit per clock on dl (left, MSB first) or on
// dr (right, LSB first), and holds mode steady for the whole frame.
//
// Ports:
//   clk        system clock, rising edge
//   clr        asynchronous active-low reset
//   load_valid din/dir_in hold a word to send
//   load_ready transmitter can accept a word this cycle
//   din        parallel word to serialize
//   dir_in     direction for this word (0 = left, 1 = right)
//   mode       direction line to the receiver, stable for the frame
//   dl, dr     serial data for left / right shift (the unused line is 0)
//   busy       frame in progress
//   last       the current bit is the final bit of the frame
//
// The outputs are decoded directly from registered state. The first bit is
// therefore visible one cycle after the accepting edge, and a reset clears
// the outputs without waiting for a clock edge.
module bidir_shift_tx #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    input  logic             dir_in,
    output logic             mode,
    output logic             dl,
    output logic             dr,
    output logic             busy,
    output logic             last
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             mode_q;
    logic             accept;

    // Output decode from registered state.
    assign busy       = (state == SHIFT);
    assign last       = busy && (cnt == CW'(WIDTH - 1));
    // Readiness on the final bit allows frames to run back to back with no gap.
    assign load_ready = !busy || last;
    assign accept     = load_valid && load_ready;
    assign mode       = mode_q;
    assign dl         = busy && !mode_q && shreg[WIDTH-1];
    assign dr         = busy &&  mode_q && shreg[0];

    // Frame sequencer: load on accept, shift toward the active output line.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            mode_q <= 1'b0;
        end else if (accept) begin
            state  <= SHIFT;
            shreg  <= din;
            cnt    <= '0;
            mode_q <= dir_in;
        end else if (state == SHIFT) begin
            shreg <= mode_q ? (shreg >> 1) : (shreg << 1);
            // cnt holds at WIDTH-1 after the final bit; only a new accept clears it.
            if (last) begin
                state <= IDLE;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bidir_shift_tx.sv
// Testbench for bidir_shift_tx. Directed and random stimulus are checked
// against a word/bit-index reference model and against a model of the
// receiving shift register.
module tb_bidir_shift_tx;

    localparam int unsigned W = 4;

    logic         clk;
    logic         clr;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] din;
    logic         dir_in;
    logic         mode;
    logic         dl;
    logic         dr;
    logic         busy;
    logic         last;

    logic         lv8;
    logic         ready8;
    logic [7:0]   din8;
    logic         dir8;
    logic         mode8;
    logic         dl8;
    logic         dr8;
    logic         busy8;
    logic         last8;

    int n_cmp;
    int n_bad;

    // Reference model: current word, direction and the index of the bit on the line.
    logic         m_busy;
    logic [W-1:0] m_word;
    logic         m_dir;
    logic         m_mode;
    int           m_k;
    // Receiver model: the bidirectional shift register on the far end.
    logic [W-1:0] rx_q;

    bidir_shift_tx #(.WIDTH(W)) u_dut4 (
        .clk       (clk),
        .clr       (clr),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .din       (din),
        .dir_in    (dir_in),
        .mode      (mode),
        .dl        (dl),
        .dr        (dr),
        .busy      (busy),
        .last      (last)
    );

    bidir_shift_tx #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .clr       (clr),
        .load_valid(lv8),
        .load_ready(ready8),
        .din       (din8),
        .dir_in    (dir8),
        .mode      (mode8),
        .dl        (dl8),
        .dr        (dr8),
        .busy      (busy8),
        .last      (last8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected {load_ready, busy, last, mode, dl, dr} from the model.
    function automatic logic [5:0] model_outs();
        logic e_last;
        logic e_bit;
        e_last = m_busy && (m_k == int'(W) - 1);
        e_bit  = m_dir ? m_word[m_k] : m_word[int'(W) - 1 - m_k];
        return {(!m_busy || e_last), m_busy, e_last, m_mode,
                (m_busy && !m_dir && e_bit), (m_busy && m_dir && e_bit)};
    endfunction

    task automatic check_outs(input string tag);
        logic [5:0] obs;
        logic [5:0] exp;
        obs = {load_ready, busy, last, mode, dl, dr};
        exp = model_outs();
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: {rdy,busy,last,mode,dl,dr} observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs and check outputs on the falling edge, then
    // advance the model and the receiver model on the rising edge.
    task automatic step(input string tag, input logic v, input logic [W-1:0] d, input logic dir);
        logic [5:0] e;
        logic       acc;
        @(negedge clk);
        load_valid = v;
        din        = d;
        dir_in     = dir;
        check_outs(tag);
        e   = model_outs();
        acc = v && e[5];
        @(posedge clk);
        rx_q = mode ? {dr, rx_q[W-1:1]} : {rx_q[W-2:0], dl};
        if (e[3]) begin
            n_cmp++;
            assert (rx_q === m_word) else begin
                n_bad++;
                $error("FAIL %s_rx: receiver q observed %b expected %b", tag, rx_q, m_word);
            end
        end
        if (acc) begin
            m_busy = 1'b1;
            m_word = d;
            m_dir  = dir;
            m_mode = dir;
            m_k    = 0;
        end else if (m_busy) begin
            if (m_k == int'(W) - 1) m_busy = 1'b0;
            else                    m_k++;
        end
    endtask

    initial begin
        logic [7:0] w8;
        logic [7:0] rx8;
        logic       e8bit;
        n_cmp      = 0;
        n_bad      = 0;
        m_busy     = 1'b0;
        m_word     = '0;
        m_dir      = 1'b0;
        m_mode     = 1'b0;
        m_k        = 0;
        rx_q       = '0;
        load_valid = 1'b0;
        din        = '0;
        dir_in     = 1'b0;
        lv8        = 1'b0;
        din8       = '0;
        dir8       = 1'b0;
        clr        = 1'b1;
        #1 clr = 1'b0;
        #2 check_outs("reset");
        @(negedge clk);
        clr = 1'b1;

        // Left frame 1011: dl 1,0,1,1.
        step("l_acc", 1'b1, 4'b1011, 1'b0);
        for (int i = 0; i < 4; i++) step("l_bit", 1'b0, 4'b0000, 1'b0);
        step("l_idle", 1'b0, 4'b0000, 1'b0);

        // Right frame 1011: dr 1,1,0,1.
        step("r_acc", 1'b1, 4'b1011, 1'b1);
        for (int i = 0; i < 4; i++) step("r_bit", 1'b0, 4'b0000, 1'b0);
        step("r_idle", 1'b0, 4'b0000, 1'b0);

        // Back-to-back with a direction flip at the frame boundary.
        step("b2b_acc", 1'b1, 4'b1100, 1'b0);
        for (int i = 0; i < 4; i++) step("b2b_hold", 1'b1, 4'b0110, 1'b1);
        for (int i = 0; i < 4; i++) step("b2b_bit", 1'b0, 4'b0000, 1'b0);
        step("b2b_idle", 1'b0, 4'b0000, 1'b0);

        // A load pulse while busy is ignored.
        step("bp_acc", 1'b1, 4'b1001, 1'b0);
        step("bp_bit0", 1'b0, 4'b0000, 1'b0);
        step("bp_pulse", 1'b1, 4'b1111, 1'b1);
        step("bp_bit2", 1'b0, 4'b0000, 1'b0);
        step("bp_bit3", 1'b0, 4'b0000, 1'b0);
        step("bp_idle", 1'b0, 4'b0000, 1'b0);

        // Asynchronous reset during bit 2, then a fresh frame.
        step("rst_acc", 1'b1, 4'b0111, 1'b0);
        step("rst_bit0", 1'b0, 4'b0000, 1'b0);
        step("rst_bit1", 1'b0, 4'b0000, 1'b0);
        @(negedge clk);
        check_outs("rst_bit2");
        #2 clr = 1'b0;
        m_busy = 1'b0;
        m_mode = 1'b0;
        rx_q   = '0;
        #1 check_outs("rst_async");
        @(negedge clk);
        clr = 1'b1;
        step("rst_new", 1'b1, 4'b1110, 1'b1);
        for (int i = 0; i < 4; i++) step("rst_newbit", 1'b0, 4'b0000, 1'b0);

        // Random traffic, including valid held across busy periods.
        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(0, 2) != 0), W'($urandom), 1'($urandom));
        end
        step("rand_end", 1'b0, 4'b0000, 1'b0);

        // WIDTH=8 left frame A5: dl 1,0,1,0,0,1,0,1 over exactly 8 busy cycles.
        w8  = 8'hA5;
        rx8 = '0;
        @(negedge clk);
        lv8  = 1'b1;
        din8 = w8;
        dir8 = 1'b0;
        n_cmp++;
        assert ({ready8, busy8} === 2'b10) else begin
            n_bad++;
            $error("FAIL w8_ready: {rdy,busy} observed %b expected 10", {ready8, busy8});
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            lv8   = 1'b0;
            e8bit = w8[7 - k];
            n_cmp++;
            assert ({busy8, last8, mode8, dl8, dr8} === {1'b1, (k == 7), 1'b0, e8bit, 1'b0}) else begin
                n_bad++;
                $error("FAIL w8_bit%0d: {busy,last,mode,dl,dr} observed %b expected %b", k,
                       {busy8, last8, mode8, dl8, dr8}, {1'b1, (k == 7), 1'b0, e8bit, 1'b0});
            end
            rx8 = {rx8[6:0], dl8};
        end
        @(negedge clk);
        n_cmp++;
        assert ({ready8, busy8, last8, dl8, dr8} === 5'b10000) else begin
            n_bad++;
            $error("FAIL w8_idle: {rdy,busy,last,dl,dr} observed %b expected 10000",
                   {ready8, busy8, last8, dl8, dr8});
        end
        n_cmp++;
        assert (rx8 === w8) else begin
            n_bad++;
            $error("FAIL w8_rx: receiver q observed %h expected %h", rx8, w8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
